// File: rtl/alu_pkg.sv
// Shared types for the ALU execution pipe: opcode encoding and flag layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_NOT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_op_e;

  // Packed MSB-first, so the 4-bit view is {N,Z,C,V}.
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: computes result and {N,Z,C,V} for one opcode/operand pair.
// Latency: combinational, no state.
// Backpressure: none; the surrounding pipe decides when the outputs are captured.
// Ports: op/a/b in, result/flags out. Shift amount is b[$clog2(WIDTH)-1:0].
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags
);

  localparam int SHW = $clog2(WIDTH);

  // Bitwise complements of both operands, one cell per bit.
  logic [WIDTH-1:0] a_n;
  logic [WIDTH-1:0] b_n;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cpl
    alu_cpl_cell u_cpl_a (.a(a[i]), .y(a_n[i]));
    alu_cpl_cell u_cpl_b (.a(b[i]), .y(b_n[i]));
  end

  // Shared adder: SUB is a + ~b + 1, so the carry-out directly means "no borrow".
  logic             is_sub;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;

  assign is_sub = (op == ALU_SUB);
  assign addend = is_sub ? b_n : b;
  assign sum    = {1'b0, a} + {1'b0, addend} + {{WIDTH{1'b0}}, is_sub};

  // Shifts carry one extra bit so the last bit shifted out lands in a fixed
  // position; with a zero shift that position holds the padding zero.
  logic [SHW-1:0] sh;
  logic [WIDTH:0] sll_ext;
  logic [WIDTH:0] srl_ext;

  assign sh      = b[SHW-1:0];
  assign sll_ext = {1'b0, a} << sh;
  assign srl_ext = {a, 1'b0} >> sh;

  logic [3:0] f;

  always_comb begin
    result = '0;
    f      = '0;
    case (op)
      ALU_ADD, ALU_SUB: begin
        result    = sum[WIDTH-1:0];
        f[FLAG_C] = sum[WIDTH];
        // Overflow: both addends share a sign that the result does not.
        f[FLAG_V] = (a[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_NOT: result = a_n;
      ALU_SLL: begin
        result    = sll_ext[WIDTH-1:0];
        f[FLAG_C] = sll_ext[WIDTH];
      end
      ALU_SRL: begin
        result    = srl_ext[WIDTH:1];
        f[FLAG_C] = srl_ext[0];
      end
      default: result = '0;
    endcase
    f[FLAG_N] = result[WIDTH-1];
    f[FLAG_Z] = (result == '0);
  end

  assign flags = alu_flags_t'(f);

endmodule

// File: rtl/alu_cpl_cell.sv
// 1-bit complement cell, the leaf used to build wide bitwise inverters.
// Latency: combinational.
// Backpressure: none.
// Ports: a - input bit, y - inverted bit.
module alu_cpl_cell (
  input  logic a,
  output logic y
);

  assign y = ~a;

endmodule

// File: rtl/alu_op_pipe.sv
// Two-stage ALU pipe: S1 registers the request, S2 registers the alu_core result.
// Latency: request accepted at edge k shows out_valid after edge k+1; 1 op/cycle.
// Backpressure: out_ready low stalls S2 then S1; holds 2 requests, output stable.
// Ports: clk/rst_n; in_valid/in_ready/in_op/in_a/in_b request side;
//        out_valid/out_ready/out_result/out_flags result side; op_count counts
//        completed output handshakes (wraps).
module alu_op_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic [CNT_W-1:0] op_count
);

  logic             s1_valid;
  alu_op_e          s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_result;
  alu_flags_t       s2_flags;

  logic [WIDTH-1:0] core_result;
  alu_flags_t       core_flags;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op     (s1_op),
    .a      (s1_a),
    .b      (s1_b),
    .result (core_result),
    .flags  (core_flags)
  );

  // Each stage may load when it is empty or its successor is draining, so a
  // full pipe still accepts a new request in the cycle the output handshakes.
  logic s2_load;
  assign s2_load  = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_op     <= ALU_ADD;
      s1_a      <= '0;
      s1_b      <= '0;
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_flags  <= '0;
      op_count  <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_op <= alu_op_e'(in_op);
          s1_a  <= in_a;
          s1_b  <= in_b;
        end
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_result <= core_result;
          s2_flags  <= core_flags;
        end
      end
      if (s2_valid && out_ready) begin
        op_count <= op_count + CNT_W'(1);
      end
    end
  end

  assign out_valid  = s2_valid;
  assign out_result = s2_result;
  assign out_flags  = s2_flags;

endmodule

// File: tb/tb_alu_op_pipe.sv
module tb_alu_op_pipe;
  import alu_pkg::*;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic [3:0]    out_flags;
  logic [CW-1:0] op_count;

  always #5 clk = ~clk;

  alu_op_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .op_count   (op_count)
  );

  // Scoreboard entries are {result[7:0], N, Z, C, V}.
  logic [11:0]   sb[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic [CW-1:0] cnt_m = '0;
  logic          held_v = 1'b0;
  logic [11:0]   held_d = '0;
  int            cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model written with integer arithmetic, independent of the adder trick.
  function automatic logic [11:0] model(input alu_op_e op, input logic [7:0] a, input logic [7:0] b);
    int s, sa, sbv, sh;
    logic [7:0] r;
    logic c, v;
    c = 1'b0; v = 1'b0; r = '0;
    sa = int'($signed(a)); sbv = int'($signed(b)); sh = int'(b) % 8;
    case (op)
      ALU_ADD: begin s = int'(a) + int'(b); r = s[7:0]; c = (s > 255);
                     v = ((sa + sbv) > 127) || ((sa + sbv) < -128); end
      ALU_SUB: begin s = int'(a) - int'(b); r = s[7:0]; c = (a >= b);
                     v = ((sa - sbv) > 127) || ((sa - sbv) < -128); end
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_NOT: r = ~a;
      ALU_SLL: begin s = int'(a) << sh; r = s[7:0]; c = (sh != 0) && s[8]; end
      default: begin r = a >> sh; c = (sh != 0) && a[sh-1]; end
    endcase
    return {r, r[7], (r == 8'h00), c, v};
  endfunction

  // Output monitor: compares every output handshake against the scoreboard,
  // tracks the completed-op count and checks held outputs stay put.
  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      chk("op_count", op_count, cnt_m);
      if (held_v && out_valid) chk("held_stable", {out_result, out_flags}, held_d);
      if (out_valid && out_ready) begin
        chk("unexpected_out", (sb.size() != 0), 1);
        if (sb.size() != 0) chk("result_flags", {out_result, out_flags}, sb.pop_front());
        cnt_m = cnt_m + 4'd1;
      end
      held_v = out_valid && !out_ready;
      held_d = {out_result, out_flags};
    end
  end

  task automatic drive(input alu_op_e op, input logic [7:0] a, input logic [7:0] b);
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
  endtask

  // Waits (bounded) for the negedge that precedes the accepting edge, then queues exp.
  task automatic accept(input logic [11:0] exp);
    bit ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_vec++; n_err++;
      $error("FAIL accept_timeout: observed in_ready=0 expected 1");
    end else begin
      sb.push_back(exp);
    end
  endtask

  task automatic send(input alu_op_e op, input logic [7:0] a, input logic [7:0] b, input logic [11:0] exp);
    drive(op, a, b);
    accept(exp);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    sb.delete();
    cnt_m = '0;
    #1;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int c0, c1;
    logic [7:0] ra;
    rst_n = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_flags", out_flags, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;

    // First-transaction latency.
    send(ALU_ADD, 8'hFF, 8'h01, {8'h00, 4'b0110});
    idle();
    @(negedge clk); chk("lat_not_yet", out_valid, 0);
    @(negedge clk); chk("lat_valid", out_valid, 1);

    // Directed opcode vectors, back to back.
    send(ALU_ADD, 8'h7F, 8'h01, {8'h80, 4'b1001});
    send(ALU_SUB, 8'h10, 8'h20, {8'hF0, 4'b1000});
    send(ALU_SUB, 8'h80, 8'h01, {8'h7F, 4'b0011});
    send(ALU_SUB, 8'h33, 8'h33, {8'h00, 4'b0110});
    send(ALU_NOT, 8'hA5, 8'h3C, {8'h5A, 4'b0000});
    send(ALU_SLL, 8'h81, 8'h01, {8'h02, 4'b0010});
    send(ALU_SRL, 8'h01, 8'h01, {8'h00, 4'b0110});
    send(ALU_SRL, 8'h01, 8'h00, {8'h01, 4'b0000});
    send(ALU_XOR, 8'hF0, 8'hFF, {8'h0F, 4'b0000});
    send(ALU_AND, 8'hF0, 8'h3C, {8'h30, 4'b0000});
    send(ALU_OR,  8'h80, 8'h01, {8'h81, 4'b1000});
    send(ALU_SLL, 8'h03, 8'h07, {8'h80, 4'b1010});
    send(ALU_SRL, 8'h80, 8'h09, {8'h40, 4'b0000});
    idle();
    repeat (4) @(negedge clk);
    chk("directed_drained", sb.size(), 0);

    // Reset with both stages full discards everything in flight.
    @(posedge clk); #1 out_ready = 1'b0;
    send(ALU_ADD, 8'h01, 8'h02, {8'h03, 4'b0000});
    send(ALU_ADD, 8'h04, 8'h05, {8'h09, 4'b0000});
    idle();
    @(negedge clk); chk("full_before_rst", out_valid, 1);
    chk("full_in_ready", in_ready, 0);
    #2 rst_n = 1'b0;
    sb.delete();
    cnt_m = '0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_result", out_result, 0);
    chk("midrst_out_flags", out_flags, 0);
    chk("midrst_op_count", op_count, 0);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
    #1 chk("post_rst_in_ready", in_ready, 1);
    repeat (4) begin
      @(negedge clk); chk("no_stale", out_valid, 0);
    end

    // Backpressure: two accepted, third stalls, then drain in order.
    @(posedge clk); #1 out_ready = 1'b0;
    send(ALU_ADD, 8'h11, 8'h22, {8'h33, 4'b0000});
    send(ALU_SUB, 8'h05, 8'h05, {8'h00, 4'b0110});
    drive(ALU_OR, 8'h80, 8'h01);
    @(negedge clk); chk("bp_in_ready", in_ready, 0);
    ra = out_result;
    repeat (3) begin
      @(negedge clk);
      chk("bp_stall", in_ready, 0);
      chk("bp_result_hold", out_result, ra);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    accept({8'h81, 4'b1000});
    idle();
    @(negedge clk); chk("bp_stream2", out_valid, 1);
    @(negedge clk); chk("bp_stream3", out_valid, 1);
    @(negedge clk); chk("bp_count", op_count, 3);
    chk("bp_empty", out_valid, 0);

    // Full-rate stream of 17 ADDs; counter wraps to 1.
    do_reset();
    c0 = 0; c1 = 0;
    for (int i = 0; i < 17; i++) begin
      logic [7:0] a, b;
      a = 8'(i * 37);
      b = 8'(i * 11 + 5);
      send(ALU_ADD, a, b, model(ALU_ADD, a, b));
      if (i == 0) c0 = cyc;
      if (i == 16) c1 = cyc;
      if (i >= 2) chk("stream_no_gap", out_valid, 1);
    end
    chk("stream_rate", c1 - c0, 16);
    idle();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("wrap_count", op_count, 1);
    chk("stream_empty", out_valid, 0);

    begin
      bit done = 1'b0;
      for (int t = 0; t < 20; t++) begin
        if (sb.size() == 0) begin done = 1'b1; break; end
        @(negedge clk);
      end
      chk("final_drain", done, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_op_pipe.md
Name: alu_op_pipe

Overview:
Two-stage registered ALU execution pipe.
- Accepts an opcode and two operands over a valid/ready handshake.
- Computes the result and flags, including bitwise complement and subtraction via complement.
- Presents the registered result downstream over a valid/ready handshake.
- Sits between the instruction/operand source and the result writeback logic. Feeds the per-bit ALU operation cells through its alu_core sub-module.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
CNT_W, 16, width of the completed-operation counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream request valid
in_ready  output  1  pipe can accept a request this cycle
in_op  input  3  opcode (alu_pkg::alu_op_e)
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B (shift amount = low $clog2(WIDTH) bits for shifts)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_result  output  WIDTH  result
out_flags  output  4  {N,Z,C,V}
op_count  output  CNT_W  completed output handshakes, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst_n low, asynchronous):
  - s1_valid=0 and s2_valid=0, so out_valid=0.
  - out_result=0, out_flags=0, op_count=0.
  - in_ready=1 combinationally while in reset-released idle.
  - Reset mid-operation discards all in-flight requests. No output is produced for them.
- Stage S1 registers {op,a,b} on input handshake (in_valid && in_ready).
- Stage S2 registers alu_core(S1) result and flags.
- s2_load = !s2_valid || out_ready.
- in_ready = !s1_valid || s2_load (combinational; no dependency on in_valid).
- S1 update when in_ready:
  - s1_valid <= in_valid.
  - Capture the payload only on handshake. The payload may be held otherwise.
- S2 update when s2_load:
  - s2_valid <= s1_valid.
  - Result and flags update only when s1_valid=1.
- Latency: a request accepted at edge k has out_valid=1 after edge k+1. Throughput is 1 op/cycle with out_ready=1.
- Backpressure:
  - With out_ready=0, the pipe holds at most 2 requests.
  - out_result and out_flags stay stable while out_valid && !out_ready.
  - Ordering is strict FIFO. No drop, no duplication.
- Simultaneous input and output handshake in the same cycle with both stages full: S2 takes S1 and S1 takes the new input.
- op_count increments on each out_valid && out_ready edge and wraps at all-ones to 0.
- Opcodes and arithmetic (mod 2^WIDTH):
  - ADD=0: a+b; C=carry-out; V=signed overflow.
  - SUB=1: a+~b+1; C=1 iff a>=b unsigned (no borrow); V=signed overflow.
  - AND=2, OR=3, XOR=4: bitwise; C=0, V=0.
  - NOT=5: ~a (b ignored); C=0, V=0.
  - SLL=6 / SRL=7: logical shift of a by b[$clog2(WIDTH)-1:0].
    - C = last bit shifted out.
    - C=0 for shift 0. V=0.
- For all opcodes: Z = (result==0); N = result[WIDTH-1].
- All 8 encodings are legal. No error path.

Decomposition:
- alu_pkg holds:
  - typedef enum logic [2:0] alu_op_e {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOT, ALU_SLL, ALU_SRL}
  - typedef struct packed alu_flags_t {n, z, c, v}
  - localparams for flag bit positions.
- Sub-module alu_core: purely combinational, parameterised by WIDTH. Inputs op/a/b; outputs result/flags.
  - Complement (NOT and SUB's ~b) is built from WIDTH instances of the team's 1-bit complement cell via generate.
- alu_op_pipe holds only the pipeline registers, handshake logic and counter.

Test Plan:
- Reset: assert rst_n=0 asynchronously with both stages full -> out_valid=0, out_result=0x00, out_flags=0, op_count=0 immediately. After release, in_ready=1 and no stale result ever appears.
- ADD: ADD 0xFF+0x01 -> out_result=0x00, flags N=0 Z=1 C=1 V=0, out_valid one cycle after the accept edge. ADD 0x7F+0x01 -> 0x80, N=1 V=1 C=0.
- SUB: SUB 0x10-0x20 -> 0xF0, N=1 Z=0 C=0 V=0. SUB 0x80-0x01 -> 0x7F, C=1 V=1. SUB 0x33-0x33 -> 0x00, Z=1 C=1.
- Logic/shift:
  - NOT a=0xA5 -> 0x5A, C=0.
  - SLL 0x81 by 1 -> 0x02, C=1.
  - SRL 0x01 by 1 -> 0x00, Z=1 C=1.
  - SRL 0x01 by 0 -> 0x01, C=0.
  - XOR 0xF0^0xFF -> 0x0F.
- Backpressure: with out_ready=0, offer 3 ops -> exactly 2 accepted, then in_ready=0 and out_result stable. Raise out_ready -> the 3 results emerge in order with no gaps once streaming, op_count=3.
- Throughput/wrap: with CNT_W=4, stream 17 ADDs with in_valid=out_ready=1 -> one result per cycle after 1-cycle fill, op_count ends at 1 (wrapped).
